run_detect_scheduler: RTL and testbench
=======================================

RUN_DETECT_SCHEDULER -- requirements
Module: run_detect_scheduler

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cfg_len  input  3  required run length L. Values 0 and 1 SHALL be treated as 2.
REQ-005 cfg_load  input  1  single-cycle pulse that latches cfg_len and clears all contexts.
REQ-006 req0_valid, req1_valid  input  1 each  requester n offers a bit.
REQ-007 req0_bit, req1_bit  input  1 each  offered bit (w).
REQ-008 req0_ready, req1_ready  output  1 each  shared detector accepts requester n's bit this cycle.
REQ-009 out_valid  output  1  registered result strobe.
REQ-010 out_chan  output  1  channel that produced the result.
REQ-011 out_z  output  1  run of L identical bits detected.
REQ-012 match_cnt0, match_cnt1  output  8 each  per-channel count of z=1 results.

Function
REQ-013 The block SHALL time-share a single run-length detector between two requesters, keeping a per-channel context: last bit (1b) and run count (3b, 0..L).
REQ-014 FSM states SHALL be INIT and RUN. Transitions: reset -> INIT; INIT -> RUN unconditionally after 1 cycle; RUN -> INIT on cfg_load=1.
REQ-015 In INIT, both readys SHALL be 0, both contexts SHALL be cleared (count=0), and L SHALL be latched from cfg_len.
REQ-016 In RUN with cfg_load=1, both readys SHALL be 0 in that cycle, and no transfer SHALL occur.
REQ-017 In RUN with cfg_load=0, grant SHALL go to the only valid requester. When both requesters are valid, grant SHALL go to the channel not served last (round-robin).
REQ-018 reqN_ready SHALL be combinational: state==RUN && !cfg_load && grant==N. At most one ready SHALL be high per cycle.
REQ-019 A transfer SHALL occur when reqN_valid && reqN_ready. Exactly one bit SHALL be consumed per transfer, and the last-served pointer SHALL update to N.
REQ-020 Context update on transfer:
- count==0: count=1, last=bit.
- bit==last: count=min(count+1, L).
- otherwise: count=1, last=bit.
REQ-021 z SHALL be 1 iff the updated count equals L. Overlap is allowed, so once saturated, each further identical bit SHALL yield z=1.
REQ-022 Runs of 0s and runs of 1s SHALL both be detected.
REQ-023 Result latency SHALL be 1 cycle: on the clock edge ending a transfer, out_valid=1, out_chan=N, out_z=z. In cycles without a transfer, out_valid=0 and out_chan/out_z SHALL hold their last values.
REQ-024 The context of a channel not granted SHALL be unchanged. An idle requester SHALL never reset its own run.
REQ-025 matchN_cnt SHALL increment when a result with z=1 for channel N is produced. It SHALL saturate at 255.
REQ-026 A cfg_load pulse SHALL:
- clear both contexts and both match counters;
- re-latch L;
- reset the last-served pointer to 1, so channel 0 wins the next tie.
REQ-027 A cfg_load during a transfer-free cycle SHALL NOT generate out_valid.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL be forced to the following values:
- state=INIT;
- contexts cleared;
- last-served=1;
- L latched from cfg_len (0/1 treated as 2);
- out_valid=0, out_chan=0, out_z=0;
- match_cnt0=match_cnt1=0.
REQ-029 Reset SHALL override cfg_load and any transfer in the same cycle. A run in progress mid-stream SHALL be discarded.
REQ-030 readys SHALL be 0 during reset and in the first cycle after it (INIT).

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Ch0 only, L=4, bits 0,0,0,0,0,1 -> out_z=0,0,0,1,1,0 on consecutive out_valid with out_chan=0; match_cnt0=2.
- Both valid every cycle, L=4, ch0 sends 1s and ch1 sends 0s -> grants alternate 0,1,0,1,... Each channel's 4th bit gives z=1, with no cross-channel interference.
- L=4, ch0 sends 1,1,1, idles 5 cycles while ch1 transfers, then sends 1 -> z=1 on that bit.
- cfg_len=3 with cfg_load mid-run after ch0 has sent 1,1 -> ready=0 for 2 cycles, counters=0; then ch0 sends 1,1,1 -> z=0,0,1.
- reset asserted mid-run while both requesters are valid -> next cycle out_valid=0, counters=0, readys=0; readys resume the following cycle with ch0 granted first.
- cfg_len=0 -> L=2: bits 1,0,0 -> z=0,0,1. 300 consecutive matches -> match_cnt0 saturates at 255.

Source files
------------

// File: rtl/run_detect_scheduler.sv
// Two-requester run-length detector sharing one datapath: round-robin grant,
// per-channel run context, registered result strobe and per-channel match counters.
module run_detect_scheduler (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] cfg_len,
   input  logic       cfg_load,
   input  logic       req0_valid,
   input  logic       req1_valid,
   input  logic       req0_bit,
   input  logic       req1_bit,
   output logic       req0_ready,
   output logic       req1_ready,
   output logic       out_valid,
   output logic       out_chan,
   output logic       out_z,
   output logic [7:0] match_cnt0,
   output logic [7:0] match_cnt1
);

   typedef enum logic {INIT, RUN} state_t;

   state_t     state, state_nx;
   logic [2:0] len_q, len_eff;
   logic       last_served;
   logic       last0, last1;
   logic [2:0] cnt0, cnt1;
   logic       grant, xfer, sel_bit, sel_last, z;
   logic [2:0] sel_cnt, cnt_nx;

   always_comb len_eff = (cfg_len < 3'd2) ? 3'd2 : cfg_len;

   always_comb begin
      state_nx   = state;
      grant      = ~last_served;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         INIT:    state_nx = RUN;
         RUN:     if (cfg_load) state_nx = INIT;
         default: state_nx = INIT;
      endcase
      if (req0_valid && !req1_valid)
         grant = 1'b0;
      else if (req1_valid && !req0_valid)
         grant = 1'b1;
      // reset gates the readys too, so nothing is offered while a run is being discarded
      if (state == RUN && !cfg_load && !reset) begin
         req0_ready = ~grant;
         req1_ready = grant;
      end
      xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      sel_bit  = grant ? req1_bit : req0_bit;
      sel_last = grant ? last1    : last0;
      sel_cnt  = grant ? cnt1     : cnt0;
      if (sel_cnt == 3'd0 || sel_bit != sel_last)
         cnt_nx = 3'd1;
      else if (sel_cnt >= len_q)
         cnt_nx = len_q;
      else
         cnt_nx = sel_cnt + 3'd1;
      z = (cnt_nx == len_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= INIT;
         cnt0        <= '0;
         cnt1        <= '0;
         last0       <= 1'b0;
         last1       <= 1'b0;
         last_served <= 1'b1;
         len_q       <= len_eff;
         out_valid   <= 1'b0;
         out_chan    <= 1'b0;
         out_z       <= 1'b0;
         match_cnt0  <= '0;
         match_cnt1  <= '0;
      end else begin
         state     <= state_nx;
         out_valid <= xfer;
         if (state == INIT || cfg_load) begin
            cnt0  <= '0;
            cnt1  <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
            len_q <= len_eff;
         end else if (xfer) begin
            if (grant) begin
               cnt1  <= cnt_nx;
               last1 <= sel_bit;
            end else begin
               cnt0  <= cnt_nx;
               last0 <= sel_bit;
            end
         end
         if (cfg_load) begin
            last_served <= 1'b1;
            match_cnt0  <= '0;
            match_cnt1  <= '0;
         end else if (xfer) begin
            last_served <= grant;
            out_chan    <= grant;
            out_z       <= z;
            if (z && !grant && match_cnt0 != 8'hFF) match_cnt0 <= match_cnt0 + 8'd1;
            if (z &&  grant && match_cnt1 != 8'hFF) match_cnt1 <= match_cnt1 + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Directed bench for run_detect_scheduler: per-cycle vector table plus
// hand sequences for reload, mid-run reset and counter saturation.
module tb_run_detect_scheduler;

   logic       clock = 1'b0;
   logic       reset, cfg_load;
   logic [2:0] cfg_len;
   logic       req0_valid, req1_valid, req0_bit, req1_bit;
   logic       req0_ready, req1_ready, out_valid, out_chan, out_z;
   logic [7:0] match_cnt0, match_cnt1;

   int errors = 0;
   int checks = 0;

   run_detect_scheduler dut (
      .clock(clock), .reset(reset), .cfg_len(cfg_len), .cfg_load(cfg_load),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_bit(req0_bit), .req1_bit(req1_bit),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_chan(out_chan), .out_z(out_z),
      .match_cnt0(match_cnt0), .match_cnt1(match_cnt1)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst, ld;
      logic [2:0] len;
      logic       v0, b0, v1, b1;
      logic       ck, r0, r1;
      logic       ov, oc, oz;
      logic [7:0] m0, m1;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int rst, ld, len, v0, b0, v1, b1,
                      input int ck, r0, r1, ov, oc, oz, m0, m1);
      vec_t v;
      v.rst = 1'(rst); v.ld = 1'(ld); v.len = 3'(len);
      v.v0 = 1'(v0); v.b0 = 1'(b0); v.v1 = 1'(v1); v.b1 = 1'(b1);
      v.ck = 1'(ck); v.r0 = 1'(r0); v.r1 = 1'(r1);
      v.ov = 1'(ov); v.oc = 1'(oc); v.oz = 1'(oz);
      v.m0 = 8'(m0); v.m1 = 8'(m1);
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drive inputs just after a rising edge, then move to the falling edge
   task automatic set_in(input logic rst, ld, input logic [2:0] len,
                         input logic v0, b0, v1, b1);
      reset = rst; cfg_load = ld; cfg_len = len;
      req0_valid = v0; req0_bit = b0; req1_valid = v1; req1_bit = b1;
      @(negedge clock);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_rdy(input string tag, input int r0, input int r1);
      chk({tag, ".req0_ready"}, int'(req0_ready), r0);
      chk({tag, ".req1_ready"}, int'(req1_ready), r1);
   endtask

   initial begin
      // rst ld len v0 b0 v1 b1 | ck r0 r1 | ov oc oz m0 m1
      add(1,0,4, 0,0,0,0, 1,0,0, 0,0,0, 0,0);
      add(0,0,4, 0,0,0,0, 1,0,0, 0,0,0, 0,0);
      // ch0 alone: 0,0,0,0,0,1
      add(0,0,4, 1,0,0,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 1,0,0,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 1,0,0,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 1,0,0,0, 1,1,0, 1,0,1, 1,0);
      add(0,0,4, 1,0,0,0, 1,1,0, 1,0,1, 2,0);
      add(0,0,4, 1,1,0,0, 1,1,0, 1,0,0, 2,0);
      add(0,0,4, 0,0,0,0, 0,0,0, 0,0,0, 2,0);
      // reload, then both valid: ch0 1s, ch1 0s, alternating grant
      add(0,1,4, 0,0,0,0, 1,0,0, 0,0,0, 0,0);
      add(0,0,4, 1,1,1,0, 1,0,0, 0,0,0, 0,0);
      add(0,0,4, 1,1,1,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 1,1,1,0, 1,0,1, 1,1,0, 0,0);
      add(0,0,4, 1,1,1,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 1,1,1,0, 1,0,1, 1,1,0, 0,0);
      add(0,0,4, 1,1,1,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 1,1,1,0, 1,0,1, 1,1,0, 0,0);
      add(0,0,4, 1,1,1,0, 1,1,0, 1,0,1, 1,0);
      add(0,0,4, 1,1,1,0, 1,0,1, 1,1,1, 1,1);
      add(0,0,4, 1,1,1,0, 1,1,0, 1,0,1, 2,1);
      add(0,0,4, 1,1,1,0, 1,0,1, 1,1,1, 2,2);
      add(0,0,4, 0,0,0,0, 0,0,0, 0,1,1, 2,2);
      // reload; ch0 sends 1,1,1, idles while ch1 runs, then one more 1
      add(0,1,4, 0,0,0,0, 1,0,0, 0,1,1, 0,0);
      add(0,0,4, 0,0,0,0, 1,0,0, 0,1,1, 0,0);
      add(0,0,4, 1,1,0,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 1,1,0,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 1,1,0,0, 1,1,0, 1,0,0, 0,0);
      add(0,0,4, 0,0,1,0, 1,0,1, 1,1,0, 0,0);
      add(0,0,4, 0,0,1,0, 1,0,1, 1,1,0, 0,0);
      add(0,0,4, 0,0,1,0, 1,0,1, 1,1,0, 0,0);
      add(0,0,4, 0,0,1,0, 1,0,1, 1,1,1, 0,1);
      add(0,0,4, 0,0,1,0, 1,0,1, 1,1,1, 0,2);
      add(0,0,4, 1,1,0,0, 1,1,0, 1,0,1, 1,2);
      add(0,0,4, 0,0,0,0, 0,0,0, 0,0,1, 1,2);

      reset = 1'b1; cfg_load = 1'b0; cfg_len = 3'd4;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_bit = 1'b0; req1_bit = 1'b0;
      tick();
      tick();

      foreach (tbl[i]) begin
         string t;
         t = $sformatf("row%0d", i);
         set_in(tbl[i].rst, tbl[i].ld, tbl[i].len, tbl[i].v0, tbl[i].b0, tbl[i].v1, tbl[i].b1);
         if (tbl[i].ck) chk_rdy(t, int'(tbl[i].r0), int'(tbl[i].r1));
         tick();
         chk({t, ".out_valid"},  int'(out_valid),  int'(tbl[i].ov));
         chk({t, ".out_chan"},   int'(out_chan),   int'(tbl[i].oc));
         chk({t, ".out_z"},      int'(out_z),      int'(tbl[i].oz));
         chk({t, ".match_cnt0"}, int'(match_cnt0), int'(tbl[i].m0));
         chk({t, ".match_cnt1"}, int'(match_cnt1), int'(tbl[i].m1));
      end

      // reload with L=3 after ch0 has sent 1,1
      set_in(0, 1, 3'd4, 0, 0, 0, 0); tick();
      set_in(0, 0, 3'd4, 0, 0, 0, 0); tick();
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 3'd4, 1, 1, 0, 0); chk_rdy("pre", 1, 0); tick();
         chk("pre.out_z", int'(out_z), 0);
      end
      set_in(0, 1, 3'd3, 1, 1, 0, 0); chk_rdy("ld", 0, 0); tick();
      chk("ld.out_valid", int'(out_valid), 0);
      chk("ld.match_cnt0", int'(match_cnt0), 0);
      chk("ld.match_cnt1", int'(match_cnt1), 0);
      set_in(0, 0, 3'd3, 1, 1, 0, 0); chk_rdy("ldinit", 0, 0); tick();
      chk("ldinit.out_valid", int'(out_valid), 0);
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 3'd3, 1, 1, 0, 0); chk_rdy($sformatf("l3_%0d", i), 1, 0); tick();
         chk($sformatf("l3_%0d.out_valid", i), int'(out_valid), 1);
         chk($sformatf("l3_%0d.out_z", i), int'(out_z), (i == 2) ? 1 : 0);
      end
      chk("l3.match_cnt0", int'(match_cnt0), 1);

      // mid-run reset with both requesters valid
      set_in(0, 0, 3'd3, 1, 1, 1, 1); chk_rdy("mr0", 0, 1); tick();
      chk("mr0.out_chan", int'(out_chan), 1);
      chk("mr0.out_z", int'(out_z), 0);
      set_in(0, 0, 3'd3, 1, 1, 1, 1); chk_rdy("mr1", 1, 0); tick();
      chk("mr1.out_z", int'(out_z), 1);
      chk("mr1.match_cnt0", int'(match_cnt0), 2);
      set_in(1, 0, 3'd3, 1, 1, 1, 1); chk_rdy("rst", 0, 0); tick();
      chk("rst.out_valid", int'(out_valid), 0);
      chk("rst.out_chan", int'(out_chan), 0);
      chk("rst.out_z", int'(out_z), 0);
      chk("rst.match_cnt0", int'(match_cnt0), 0);
      chk("rst.match_cnt1", int'(match_cnt1), 0);
      set_in(0, 0, 3'd3, 1, 1, 1, 1); chk_rdy("rstinit", 0, 0); tick();
      chk("rstinit.out_valid", int'(out_valid), 0);
      set_in(0, 0, 3'd3, 1, 1, 1, 1); chk_rdy("resume0", 1, 0); tick();
      chk("resume0.out_valid", int'(out_valid), 1);
      chk("resume0.out_chan", int'(out_chan), 0);
      chk("resume0.out_z", int'(out_z), 0);
      set_in(0, 0, 3'd3, 1, 1, 1, 1); chk_rdy("resume1", 0, 1); tick();
      chk("resume1.out_chan", int'(out_chan), 1);
      chk("resume1.out_z", int'(out_z), 0);

      // cfg_len=0 behaves as L=2; then saturate match_cnt0
      set_in(0, 1, 3'd0, 0, 0, 0, 0); tick();
      set_in(0, 0, 3'd0, 0, 0, 0, 0); tick();
      set_in(0, 0, 3'd0, 1, 1, 0, 0); tick();
      chk("l2_0.out_z", int'(out_z), 0);
      set_in(0, 0, 3'd0, 1, 0, 0, 0); tick();
      chk("l2_1.out_z", int'(out_z), 0);
      set_in(0, 0, 3'd0, 1, 0, 0, 0); tick();
      chk("l2_2.out_z", int'(out_z), 1);
      chk("l2_2.match_cnt0", int'(match_cnt0), 1);
      for (int k = 1; k <= 300; k++) begin
         set_in(0, 0, 3'd0, 1, 0, 0, 0); tick();
         if (k == 253) chk("sat253.match_cnt0", int'(match_cnt0), 254);
         if (k == 254) chk("sat254.match_cnt0", int'(match_cnt0), 255);
      end
      chk("sat.match_cnt0", int'(match_cnt0), 255);
      chk("sat.out_z", int'(out_z), 1);
      chk("sat.match_cnt1", int'(match_cnt1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
